// File: rtl/div_i4_o4_seq_pkg.sv
// div_pkg: shared FSM state type and width limit for the sequential divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int MAX_WIDTH = 8;
  localparam int CNT_W = $clog2(MAX_WIDTH + 1);
endpackage

// File: rtl/div_i4_o4_seq_if.sv
// div_i4_o4_seq_if: operand/result handshake bundle for the sequential divider
interface div_i4_o4_seq_if #(parameter int WIDTH = 2);
  logic in_valid, in_ready, out_valid, out_ready, dbz, chk_err;
  logic [WIDTH-1:0] dividend, divisor, quotient, remainder;
  modport master(output in_valid, dividend, divisor, out_ready,
                 input in_ready, out_valid, quotient, remainder, dbz, chk_err);
  modport slave(input in_valid, dividend, divisor, out_ready,
                output in_ready, out_valid, quotient, remainder, dbz, chk_err);
endinterface

// File: rtl/div_i4_o4_seq_check.sv
// div_check: combinational consistency check of a finished division
module div_check #(parameter int WIDTH = 2) (
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic [WIDTH-1:0] quotient_i,
  input  logic [WIDTH-1:0] remainder_i,
  output logic             err_o
);
  logic [2*WIDTH-1:0] recon;
  always_comb begin
    recon = (2*WIDTH)'(quotient_i) * (2*WIDTH)'(divisor_i) + (2*WIDTH)'(remainder_i);
    err_o = (recon != (2*WIDTH)'(dividend_i)) || (remainder_i >= divisor_i);
  end
endmodule

// File: rtl/div_i4_o4_seq.sv
// div_i4_o4_seq: restoring divider, one quotient bit per cycle; DIV_SELF_CHECK_EN adds a result check
module div_i4_o4_seq import div_pkg::*; #(parameter int WIDTH = 2) (
  input logic clk,
  input logic rst_n,
  div_i4_o4_seq_if.slave bus
);
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH:0]     sh;
  logic               ge, zero;
  // next state: capture in IDLE, shift-subtract in CALC, release on out_ready in DONE
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    dbz_d = dbz_q;
    zero = bus.divisor == '0;
    sh = {rem_q, quo_q[WIDTH-1]};
    ge = sh >= {1'b0, dvs_q};
    if (state_q == IDLE && bus.in_valid) begin
      dvs_d = bus.divisor;
      dbz_d = zero;
      rem_d = zero ? bus.dividend : '0;
      quo_d = zero ? '1 : bus.dividend;
      cnt_d = CNT_W'(WIDTH - 1);
      state_d = zero ? DONE : CALC;
    end else if (state_q == CALC) begin
      rem_d = WIDTH'(ge ? sh - {1'b0, dvs_q} : sh);
      quo_d = {quo_q[WIDTH-2:0], ge};
      cnt_d = cnt_q - 1'b1;
      state_d = cnt_q == '0 ? DONE : CALC;
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      dbz_q <= dbz_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.quotient  = bus.out_valid ? quo_q : '0;
  assign bus.remainder = bus.out_valid ? rem_q : '0;
  assign bus.dbz       = bus.out_valid & dbz_q;
`ifdef DIV_SELF_CHECK_EN
  logic [WIDTH-1:0] dvd_q;
  logic             err;
  // original dividend kept for the reconstruction check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dvd_q <= '0;
    else if (state_q == IDLE && bus.in_valid) dvd_q <= bus.dividend;
  end
  div_check #(.WIDTH(WIDTH)) u_check (
    .dividend_i(dvd_q), .divisor_i(dvs_q), .quotient_i(quo_q), .remainder_i(rem_q), .err_o(err)
  );
  assign bus.chk_err = bus.out_valid & ~dbz_q & err;
`else
  assign bus.chk_err = 1'b0;
`endif
endmodule
